// File: rtl/block_mean_calc.sv
// block_mean_calc: per-block mean luminance over a power-of-two block grid.
// Define BLOCK_MEAN_ROUND_EN for a round-half-up mean (truncating otherwise).
module block_mean_calc #(
    parameter int BLK_COLS   = 8,
    parameter int BLK_ROWS   = 4,
    parameter int BLK_W_LOG2 = 7,
    parameter int BLK_H_LOG2 = 7
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  vs_i,
    input  logic                                  de_i,
    input  logic [7:0]                            luma_i,
    output logic [7:0]                            block_mean_o,
    output logic                                  data_valid_o,
    output logic [$clog2(BLK_COLS*BLK_ROWS)-1:0]  block_idx_o,
    output logic                                  frame_done_o
);

    localparam int IMG_W = BLK_COLS << BLK_W_LOG2;
    localparam int IMG_H = BLK_ROWS << BLK_H_LOG2;
    localparam int SH    = BLK_W_LOG2 + BLK_H_LOG2;
    localparam int ACC_W = 8 + SH;
    localparam int XW    = $clog2(IMG_W) + 1;
    localparam int YW    = $clog2(IMG_H) + 1;
    localparam int CW    = $clog2(BLK_COLS);
    localparam int RW    = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
    localparam int IW    = $clog2(BLK_COLS * BLK_ROWS);

    localparam logic [YW-1:0] YMASK = YW'((1 << BLK_H_LOG2) - 1);

    typedef enum logic {
        WAIT_VS,
        ACTIVE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_vs_d;
    logic             r_de_d;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [ACC_W-1:0] r_acc    [BLK_COLS];
    logic [ACC_W-1:0] r_shadow [BLK_COLS];
    logic             r_dump;
    logic [RW-1:0]    r_dump_row;
    logic             r_emit;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;

    logic             w_vs_rise;
    logic             w_active;
    logic             w_pix;
    logic             w_eol;
    logic             w_trig;
    logic [CW-1:0]    w_xcol;
    logic [7:0]       w_mean;
    logic [IW-1:0]    w_idx;
    logic             w_last;

    assign w_vs_rise = vs_i & ~r_vs_d;
    assign w_active  = (r_state == ACTIVE) && !w_vs_rise;
    assign w_pix     = w_active && de_i && (r_x < XW'(IMG_W));
    assign w_eol     = w_active && !de_i && r_de_d;
    assign w_xcol    = CW'(r_x >> BLK_W_LOG2);
    assign w_trig    = w_pix && (r_x == XW'(IMG_W - 1))
                    && ((r_y & YMASK) == YMASK);

`ifdef BLOCK_MEAN_ROUND_EN
    localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SH - 1);
    logic [ACC_W:0] w_round;
    assign w_round = {1'b0, r_shadow[r_col]} + HALF;
    assign w_mean  = 8'(w_round >> SH);
`else
    assign w_mean  = 8'(r_shadow[r_col] >> SH);
`endif

    assign w_idx  = IW'(r_row) * IW'(BLK_COLS) + IW'(r_col);
    assign w_last = (r_col == CW'(BLK_COLS - 1))
                 && (r_row == RW'(BLK_ROWS - 1));

    always_comb begin
        w_state_nxt = r_state;
        if (w_vs_rise) begin
            w_state_nxt = ACTIVE;
        end else if (w_eol && (r_y == YW'(IMG_H - 1))) begin
            w_state_nxt = WAIT_VS;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= WAIT_VS;
            r_vs_d  <= 1'b0;
            r_de_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vs_d  <= vs_i;
            r_de_d  <= de_i;
        end
    end

    // x saturates at IMG_W so overlong lines stop accumulating
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_vs_rise) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_eol) begin
            r_x <= '0;
            r_y <= r_y + YW'(1);
        end else if (w_pix) begin
            r_x <= r_x + XW'(1);
        end
    end

    // A pixel landing on the dump edge starts the freshly cleared sum
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < BLK_COLS; c++) begin
                r_acc[c]    <= '0;
                r_shadow[c] <= '0;
            end
        end else begin
            for (int c = 0; c < BLK_COLS; c++) begin
                if (r_dump) begin
                    r_shadow[c] <= r_acc[c];
                end
                if (w_pix && (w_xcol == CW'(c))) begin
                    r_acc[c] <= (r_dump ? {ACC_W{1'b0}} : r_acc[c])
                              + ACC_W'(luma_i);
                end else if (w_vs_rise || r_dump) begin
                    r_acc[c] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dump     <= 1'b0;
            r_dump_row <= '0;
            r_emit     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
        end else begin
            r_dump     <= w_trig;
            r_dump_row <= RW'(r_y >> BLK_H_LOG2);
            if (r_dump) begin
                r_emit <= 1'b1;
                r_col  <= '0;
                r_row  <= r_dump_row;
            end else if (r_emit) begin
                if (r_col == CW'(BLK_COLS - 1)) begin
                    r_emit <= 1'b0;
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            block_mean_o <= '0;
            data_valid_o <= 1'b0;
            block_idx_o  <= '0;
            frame_done_o <= 1'b0;
        end else begin
            data_valid_o <= r_emit;
            block_mean_o <= r_emit ? w_mean : 8'd0;
            block_idx_o  <= r_emit ? w_idx : '0;
            frame_done_o <= r_emit && w_last;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn && w_trig) begin
            assert (!r_emit && !r_dump);
        end
    end
`endif

endmodule

// File: tb/tb_block_mean_calc.sv
// tb_block_mean_calc: directed + random frames against a block-sum model.
// Model follows BLOCK_MEAN_ROUND_EN the same way the design build does.
`timescale 1ns/1ps
module tb_block_mean_calc;

    localparam int BC  = 4;
    localparam int BR  = 2;
    localparam int BWL = 2;
    localparam int BHL = 1;
    localparam int W   = BC << BWL;
    localparam int H   = BR << BHL;
    localparam int SH  = BWL + BHL;
    localparam int BH  = 1 << BHL;
    localparam int BWP = 1 << BWL;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       vs_i = 1'b0;
    logic       de_i = 1'b0;
    logic [7:0] luma_i = 8'd0;
    logic [7:0] block_mean_o;
    logic       data_valid_o;
    logic [2:0] block_idx_o;
    logic       frame_done_o;

    block_mean_calc #(
        .BLK_COLS   (BC),
        .BLK_ROWS   (BR),
        .BLK_W_LOG2 (BWL),
        .BLK_H_LOG2 (BHL)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .vs_i         (vs_i),
        .de_i         (de_i),
        .luma_i       (luma_i),
        .block_mean_o (block_mean_o),
        .data_valid_o (data_valid_o),
        .block_idx_o  (block_idx_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mean;
        int idx;
        int done;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   img[H][W];
    int   got_mean[8];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] req);
        n_tests++;
        assert (got === req) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, req);
        end
    endtask

    function automatic int blk_mean(input int br, input int c);
        int s = 0;
        for (int r = br * BH; r < (br + 1) * BH; r++)
            for (int x = c * BWP; x < (c + 1) * BWP; x++)
                s += img[r][x];
`ifdef BLOCK_MEAN_ROUND_EN
        return (s + (1 << (SH - 1))) >> SH;
`else
        return s >> SH;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (frame_done_o) done_cnt++;
            if (data_valid_o) begin
                got_mean[block_idx_o] = int'(block_mean_o);
                n_tests++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_valid observed idx=%0d expected none",
                           block_idx_o);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("mean", block_mean_o, e.mean);
                    chk("idx", block_idx_o, e.idx);
                    chk("frame_done", frame_done_o, e.done);
                    chk("latency_cycle", cyc, e.cyc);
                end
            end else begin
                chk("done_without_valid", frame_done_o, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missed_valid", data_valid_o, 1);
                end
            end
        end
    end

    task automatic drive_line(input int y, input int len, input int gap,
                              input bit exp_en);
        for (int x = 0; x < len; x++) begin
            @(negedge clk);
            de_i   = 1'b1;
            luma_i = 8'(img[y][x]);
            if (exp_en && x == W - 1 && (y % BH) == BH - 1) begin
                for (int c = 0; c < BC; c++) begin
                    exp_q.push_back('{blk_mean(y / BH, c),
                                      (y / BH) * BC + c,
                                      ((y / BH) == BR - 1 && c == BC - 1) ? 1 : 0,
                                      cyc + 3 + c});
                end
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            de_i   = 1'b0;
            luma_i = 8'($urandom);
        end
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        de_i = 1'b0;
        vs_i = 1'b1;
        @(negedge clk);
        vs_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame(input int gap);
        vs_pulse();
        for (int y = 0; y < H; y++) drive_line(y, W, gap, 1'b1);
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_got();
        for (int i = 0; i < 8; i++) got_mean[i] = -1;
    endtask

    task automatic fill_rand();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = int'($urandom_range(0, 255));
    endtask

    initial begin
        int d0;
        int cols[4];
        cols[0] = 0; cols[1] = 50; cols[2] = 200; cols[3] = 255;
        clear_got();

        repeat (3) @(negedge clk);
        chk("rst_valid", data_valid_o, 0);
        chk("rst_mean", block_mean_o, 0);
        chk("rst_idx", block_idx_o, 0);
        chk("rst_done", frame_done_o, 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // constant frame
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = 100;
        d0 = done_cnt;
        frame(3);
        chk("t1_mean0", got_mean[0], 100);
        chk("t1_mean7", got_mean[7], 100);
        chk("t1_done_cnt", done_cnt, d0 + 1);

        // per-column constants
        clear_got();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = cols[x / BWP];
        frame(2);
        chk("t2_mean1", got_mean[1], 50);
        chk("t2_mean3", got_mean[3], 255);
        chk("t2_mean6", got_mean[6], 200);
        chk("t2_mean4", got_mean[4], 0);

        // rounding case: block 0 sums to 15
        clear_got();
        fill_rand();
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BWP; x++) img[y][x] = 2;
        img[0][0] = 1;
        frame(1);
`ifdef BLOCK_MEAN_ROUND_EN
        chk("t3_round_mean0", got_mean[0], 2);
`else
        chk("t3_trunc_mean0", got_mean[0], 1);
`endif

        // back-to-back lines with random content
        for (int k = 0; k < 3; k++) begin
            fill_rand();
            frame(1);
        end
        for (int k = 0; k < 3; k++) begin
            fill_rand();
            frame(int'($urandom_range(1, 4)));
        end

        // short frame: vs after two lines plus a partial line
        d0 = done_cnt;
        fill_rand();
        vs_pulse();
        drive_line(0, W, 1, 1'b1);
        drive_line(1, W, 1, 1'b1);
        drive_line(2, 3, 0, 1'b1);
        fill_rand();
        frame(1);
        chk("t5_done_cnt", done_cnt, d0 + 1);

        // reset in the middle of the last emission
        fill_rand();
        vs_pulse();
        for (int y = 0; y < H; y++) drive_line(y, W, 1, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_valid", data_valid_o, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", data_valid_o, 0);
        chk("mid_rst_mean", block_mean_o, 0);
        chk("mid_rst_idx", block_idx_o, 0);
        chk("mid_rst_done", frame_done_o, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        drive_line(0, W, 1, 1'b0);
        drive_line(1, W, 1, 1'b0);
        repeat (8) @(negedge clk);
        d0 = done_cnt;
        fill_rand();
        frame(1);
        chk("t6_done_cnt", done_cnt, d0 + 1);

        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
